des_out_fifo: RTL and testbench

DES_OUT_FIFO -- requirements
Module: des_out_fifo

---
 rtl/des_out_fifo.sv | 83 ++++++++
 tb/tb_des_out_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/des_out_fifo.sv
// Output FIFO for DES core result words: first-word-fall-through, no backpressure
// toward the core, words arriving while full are dropped and counted.
module des_out_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          valid_i,
    input  logic [0:63]   data_i,
    input  logic          accept_i,
    input  logic          clear_i,
    output logic          valid_o,
    output logic [0:63]   data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    output logic [7:0]    drop_cnt_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [0:63]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          pop;
    logic          wr_en;
    logic          drop;

    // Full/empty come from the occupancy count, so equal pointers are never ambiguous.
    assign empty_o = (count == '0);
    assign full_o  = (count == DEPTH_C);
    assign valid_o = ~empty_o;

    assign pop   = valid_o & accept_i;
    assign wr_en = valid_i & (~full_o | pop);
    assign drop  = valid_i & full_o & ~pop;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; it is unobservable while empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= data_i;
    end

    // A drop in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_i) begin
            overflow <= drop;
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign data_o     = empty_o ? '0 : mem[rd_ptr];
    assign count_o    = count;
    assign overflow_o = overflow;
    assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_des_out_fifo.sv
// Self-checking bench for des_out_fifo: scoreboard queue of expected words plus
// a reference model of count and drop flags, checked with immediate assertions.
module tb_des_out_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          valid_i;
    logic [0:63]   data_i;
    logic          accept_i;
    logic          clear_i;
    logic          valid_o;
    logic [0:63]   data_o;
    logic          empty_o;
    logic          full_o;
    logic [AW:0]   count_o;
    logic          overflow_o;
    logic [7:0]    drop_cnt_o;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] q[$];
    logic        m_ovf;
    int          m_dc;

    des_out_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .accept_i   (accept_i),
        .clear_i    (clear_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 64'(count_o), 64'(q.size()));
        chk({tag, ".empty"}, 64'(empty_o), 64'(q.size() == 0));
        chk({tag, ".full"},  64'(full_o),  64'(q.size() == DEPTH));
        chk({tag, ".ovf"},   64'(overflow_o), 64'(m_ovf));
        chk({tag, ".drops"}, 64'(drop_cnt_o), 64'(m_dc));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".count"}, 64'(count_o), 64'd0);
        chk({tag, ".valid"}, 64'(valid_o), 64'd0);
        chk({tag, ".empty"}, 64'(empty_o), 64'd1);
        chk({tag, ".full"},  64'(full_o),  64'd0);
        chk({tag, ".data"},  64'(data_o),  64'd0);
        chk({tag, ".ovf"},   64'(overflow_o), 64'd0);
        chk({tag, ".drops"}, 64'(drop_cnt_o), 64'd0);
    endtask

    // One clock cycle: drive inputs, check head word before the edge, update model, check after.
    task automatic cycle(input string tag, input logic v, input logic [63:0] d,
                         input logic a, input logic clr);
        logic        mpop, mwr, mdrop;
        logic [63:0] exp;
        valid_i  = v;
        data_i   = d;
        accept_i = a;
        clear_i  = clr;
        #1;
        chk({tag, ".valid_o"}, 64'(valid_o), 64'(q.size() > 0));
        mpop  = a && (q.size() > 0);
        mwr   = v && ((q.size() < DEPTH) || mpop);
        mdrop = v && !mwr;
        if (q.size() == 0) chk({tag, ".data_empty"}, 64'(data_o), 64'd0);
        if (mpop) begin
            exp = q.pop_front();
            chk({tag, ".data_out"}, 64'(data_o), exp);
        end
        if (mwr) q.push_back(d);
        if (clr) begin
            m_ovf = mdrop;
            m_dc  = mdrop ? 1 : 0;
        end else if (mdrop) begin
            m_ovf = 1'b1;
            if (m_dc != 255) m_dc++;
        end
        @(posedge clk_i);
        #1;
        chk_state(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 64'd0, 1'b1, 1'b0);
    endtask

    initial begin
        reset_i  = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        accept_i = 1'b0;
        clear_i  = 1'b0;
        m_ovf    = 1'b0;
        m_dc     = 0;

        // Reset held across edges with active inputs: outputs stay at reset values.
        valid_i  = 1'b1;
        accept_i = 1'b1;
        #22;
        chk_reset("reset");
        valid_i  = 1'b0;
        accept_i = 1'b0;
        reset_i  = 1'b1;
        @(posedge clk_i);
        #1;
        chk_state("post_reset");

        // Single word in and out.
        cycle("single_wr", 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        chk("single.head", 64'(data_o), 64'h0123456789ABCDEF);
        cycle("single_rd", 1'b0, 64'd0, 1'b1, 1'b0);
        chk("single.empty_data", 64'(data_o), 64'd0);

        // Fill 17 words: word 17 dropped.
        for (int i = 1; i <= 17; i++) cycle("fill17", 1'b1, 64'(i), 1'b0, 1'b0);
        chk("fill17.full", 64'(full_o), 64'd1);
        chk("fill17.drops", 64'(drop_cnt_o), 64'd1);
        drain("drain17");
        cycle("clear1", 1'b0, 64'd0, 1'b0, 1'b1);

        // Full with simultaneous write and pop: no drop, 0xAA comes out last.
        for (int i = 0; i < DEPTH; i++) cycle("fill_wp", 1'b1, 64'(100 + i), 1'b0, 1'b0);
        cycle("full_wp", 1'b1, 64'hAA, 1'b1, 1'b0);
        chk("full_wp.count", 64'(count_o), 64'd16);
        chk("full_wp.ovf", 64'(overflow_o), 64'd0);
        chk("full_wp.tail", q[DEPTH-1], 64'hAA);
        drain("drain_wp");

        // Drop counter saturation, clear, then clear colliding with a drop.
        for (int i = 0; i < DEPTH; i++) cycle("fill_sat", 1'b1, 64'(200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle("drop300", 1'b1, 64'(1000 + i), 1'b0, 1'b0);
        chk("sat.drops", 64'(drop_cnt_o), 64'd255);
        cycle("clear_sat", 1'b0, 64'd0, 1'b0, 1'b1);
        chk("clear_sat.drops", 64'(drop_cnt_o), 64'd0);
        chk("clear_sat.count", 64'(count_o), 64'd16);
        cycle("clear_drop", 1'b1, 64'h55, 1'b0, 1'b1);
        chk("clear_drop.drops", 64'(drop_cnt_o), 64'd1);
        drain("drain_sat");
        cycle("clear2", 1'b0, 64'd0, 1'b0, 1'b1);

        // Streaming across pointer wrap: 0..39 with one-cycle lag.
        for (int i = 0; i < 40; i++) begin
            cycle("stream", 1'b1, 64'(i), 1'b1, 1'b0);
            chk("stream.cnt_le1", 64'(count_o <= 1), 64'd1);
        end
        drain("drain_stream");

        // Async reset mid-stream, asserted between edges.
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 64'(500 + i), 1'b0, 1'b0);
        #2;
        reset_i = 1'b0;
        #1;
        chk_reset("async_rst");
        q.delete();
        m_ovf = 1'b0;
        m_dc  = 0;
        valid_i = 1'b1;
        data_i  = 64'hDEAD;
        @(posedge clk_i);
        #1;
        chk_reset("rst_ignore");
        valid_i = 1'b0;
        #3;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle("first_wr", 1'b1, 64'hBEEF, 1'b0, 1'b0);
        chk("first_wr.head", 64'(data_o), 64'hBEEF);
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
